carregador_operandos: RTL and testbench

CARREGADOR_OPERANDOS -- requirements
Module: carregador_operandos

---
 rtl/carregador_operandos_pkg.sv | 16 +
 rtl/detector_borda.sv | 37 +++
 rtl/carregador_operandos.sv | 116 +++++++++++
 tb/tb_carregador_operandos.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carregador_operandos_pkg.sv
// Shared definitions for the two-operand loader: FSM state encoding, operand
// width and default timing parameters.
package carregador_operandos_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESPERA_B = 2'd1,
        CALC     = 2'd2,
        MOSTRA   = 2'd3
    } estado_t;

    localparam int LARG               = 4;
    localparam int SYNC_STAGES_PADRAO = 2;
    localparam int CICLOS_CALC_PADRAO = 2;

endpackage

// File: rtl/detector_borda.sv
// Push-button synchroniser and rising-edge detector: one single-cycle evento
// per press, never for a press already held when reset is released.
module detector_borda
    import carregador_operandos_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_PADRAO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao,
    output logic evento
);

    logic [SYNC_STAGES-1:0] sinc;
    logic [SYNC_STAGES-1:0] enchido;
    logic                   historico;
    logic                   armado;

    // enchido tracks when sinc holds a real post-reset sample; armado then
    // waits for the button to be seen released before any edge counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc      <= '0;
            enchido   <= '0;
            historico <= 1'b0;
            armado    <= 1'b0;
        end else begin
            sinc      <= {sinc[SYNC_STAGES-2:0], botao};
            enchido   <= {enchido[SYNC_STAGES-2:0], 1'b1};
            historico <= sinc[SYNC_STAGES-1];
            armado    <= armado | (enchido[SYNC_STAGES-1] & ~sinc[SYNC_STAGES-1]);
        end
    end

    assign evento = sinc[SYNC_STAGES-1] & ~historico & armado;

endmodule

// File: rtl/carregador_operandos.sv
// Loads minuend and subtrahend from switches on successive button presses,
// waits for the external subtractor to settle, then captures its result.
module carregador_operandos
    import carregador_operandos_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_PADRAO,
    parameter int CICLOS_CALC = CICLOS_CALC_PADRAO
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LARG-1:0] chaves,
    input  logic            botao,
    input  logic            limpar,
    input  logic [LARG-1:0] s_in,
    input  logic            cout_in,
    output logic [LARG-1:0] a,
    output logic [LARG-1:0] b,
    output logic            cin,
    output logic [LARG-1:0] resultado,
    output logic            cout_reg,
    output logic            negativo,
    output logic            pronto,
    output logic [1:0]      estado
);

    localparam int CW = $clog2(CICLOS_CALC + 1);

    estado_t       estado_q;
    estado_t       estado_d;
    logic [CW-1:0] contador;
    logic          evento;

    detector_borda #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_detector_borda (
        .clk   (clk),
        .rst_n (rst_n),
        .botao (botao),
        .evento(evento)
    );

    assign cin    = 1'b0;
    assign estado = estado_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado_q <= OCIOSO;
        else        estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        if (limpar) begin
            estado_d = OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO:   if (evento) estado_d = ESPERA_B;
                ESPERA_B: if (evento) estado_d = CALC;
                CALC:     if (contador == '0) estado_d = MOSTRA;
                MOSTRA:   if (evento) estado_d = ESPERA_B;
                default:  estado_d = OCIOSO;
            endcase
        end
    end

    // Operands only move on accepted load events, so they are frozen while the
    // subtractor settles; presses during CALC simply fall through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            resultado <= '0;
            cout_reg  <= 1'b0;
            negativo  <= 1'b0;
            pronto    <= 1'b0;
            contador  <= '0;
        end else if (limpar) begin
            a         <= '0;
            b         <= '0;
            resultado <= '0;
            cout_reg  <= 1'b0;
            negativo  <= 1'b0;
            pronto    <= 1'b0;
            contador  <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (evento) a <= chaves;
                end
                ESPERA_B: begin
                    if (evento) begin
                        b        <= chaves;
                        contador <= CW'(CICLOS_CALC - 1);
                    end
                end
                CALC: begin
                    if (contador == '0) begin
                        resultado <= s_in;
                        cout_reg  <= cout_in;
                        negativo  <= (a < b);
                        pronto    <= 1'b1;
                    end else begin
                        contador <= contador - 1'b1;
                    end
                end
                MOSTRA: begin
                    if (evento) begin
                        pronto <= 1'b0;
                        a      <= chaves;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_operandos.sv
// Bench for carregador_operandos with an external behavioural subtractor and a
// transaction-level model of the expected operand/result registers.
module tb_carregador_operandos;
    import carregador_operandos_pkg::*;

    localparam int SYNC   = 2;
    localparam int CALC_N = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [LARG-1:0] chaves = '0;
    logic            botao = 1'b0;
    logic            limpar = 1'b0;
    logic [LARG-1:0] s_in;
    logic            cout_in;
    logic [LARG-1:0] a, b, resultado;
    logic            cin, cout_reg, negativo, pronto;
    logic [1:0]      estado;
    logic            cout_flip = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_a, m_b, m_res;
    logic       m_cout, m_neg, m_pronto;
    logic [1:0] m_estado;

    carregador_operandos #(
        .SYNC_STAGES(SYNC),
        .CICLOS_CALC(CALC_N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .chaves   (chaves),
        .botao    (botao),
        .limpar   (limpar),
        .s_in     (s_in),
        .cout_in  (cout_in),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .resultado(resultado),
        .cout_reg (cout_reg),
        .negativo (negativo),
        .pronto   (pronto),
        .estado   (estado)
    );

    // External subtractor; cout_flip decorrelates the carry from the a<b flag.
    assign s_in    = a - b - {3'b000, cin};
    assign cout_in = (a >= b) ^ cout_flip;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model rules: what each accepted event does to the visible registers.
    task automatic model_clear();
        m_a = 0; m_b = 0; m_res = 0; m_cout = 0; m_neg = 0; m_pronto = 0; m_estado = 0;
    endtask

    task automatic model_load_a(input logic [3:0] v);
        m_a = v; m_pronto = 0; m_estado = 2'd1;
    endtask

    task automatic model_load_b(input logic [3:0] v);
        m_b = v; m_estado = 2'd2;
    endtask

    task automatic model_capture();
        m_res    = m_a - m_b;
        m_neg    = (int'(m_a) < int'(m_b));
        m_cout   = (int'(m_a) >= int'(m_b)) ^ cout_flip;
        m_pronto = 1;
        m_estado = 2'd3;
    endtask

    // Clean press: button low long enough to be seen, then high until the load edge.
    task automatic press(input logic [3:0] v);
        botao = 1'b0;
        repeat (SYNC) @(negedge clk);
        @(negedge clk);
        chaves = v;
        botao  = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        botao = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a !== m_a) begin errors++; $display("FAIL reset_a got %0h want %0h", a, m_a); end
        checks++; if (b !== m_b) begin errors++; $display("FAIL reset_b got %0h want %0h", b, m_b); end
        checks++; if (resultado !== m_res) begin errors++; $display("FAIL reset_res got %0h want %0h", resultado, m_res); end
        checks++; if ({cout_reg, negativo, pronto} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {cout_reg, negativo, pronto}); end
        checks++; if (estado !== m_estado) begin errors++; $display("FAIL reset_estado got %0d want %0d", estado, m_estado); end
        checks++; if (cin !== 1'b0) begin errors++; $display("FAIL reset_cin got %b want 0", cin); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_vectors();
        cout_flip = 1'b0;
        press(4'd9); model_load_a(4'd9);
        checks++; if (a !== m_a || estado !== m_estado) begin errors++; $display("FAIL vec_load_a got a=%0h st=%0d want a=%0h st=%0d", a, estado, m_a, m_estado); end
        press(4'd3); model_load_b(4'd3);
        checks++; if (b !== m_b || estado !== m_estado) begin errors++; $display("FAIL vec_load_b got b=%0h st=%0d want b=%0h st=%0d", b, estado, m_b, m_estado); end
        repeat (CALC_N - 1) @(posedge clk);
        #1;
        checks++; if (pronto !== 1'b0 || estado !== 2'd2) begin errors++; $display("FAIL vec_early got pronto=%b st=%0d want pronto=0 st=2", pronto, estado); end
        @(posedge clk); #1;
        model_capture();
        checks++; if (resultado !== 4'd6 || negativo !== 1'b0) begin errors++; $display("FAIL vec_9m3 got res=%0h neg=%b want res=6 neg=0", resultado, negativo); end
        checks++; if (pronto !== 1'b1 || estado !== 2'd3 || cout_reg !== m_cout) begin errors++; $display("FAIL vec_9m3_flags got p=%b st=%0d c=%b want p=1 st=3 c=%b", pronto, estado, cout_reg, m_cout); end
        press(4'd3); model_load_a(4'd3);
        checks++; if (a !== m_a || pronto !== 1'b0 || estado !== m_estado || resultado !== m_res) begin errors++; $display("FAIL vec_reload got a=%0h p=%b st=%0d res=%0h want a=%0h p=0 st=%0d res=%0h", a, pronto, estado, resultado, m_a, m_estado, m_res); end
        press(4'd5); model_load_b(4'd5);
        repeat (CALC_N) @(posedge clk);
        #1;
        model_capture();
        checks++; if (resultado !== 4'hE || negativo !== 1'b1) begin errors++; $display("FAIL vec_3m5 got res=%0h neg=%b want res=e neg=1", resultado, negativo); end
        checks++; if (cout_reg !== m_cout || pronto !== 1'b1) begin errors++; $display("FAIL vec_3m5_flags got c=%b p=%b want c=%b p=1", cout_reg, pronto, m_cout); end
    endtask

    task automatic test_random(input int n);
        logic [3:0] va, vb;
        for (int i = 0; i < n; i++) begin
            va = 4'($urandom_range(0, 15));
            vb = 4'($urandom_range(0, 15));
            press(va); model_load_a(va);
            checks++; if (a !== m_a || estado !== m_estado || pronto !== m_pronto || resultado !== m_res) begin errors++; $display("FAIL rnd_a[%0d] got a=%0h st=%0d p=%b res=%0h want a=%0h st=%0d p=%b res=%0h", i, a, estado, pronto, resultado, m_a, m_estado, m_pronto, m_res); end
            cout_flip = 1'($urandom_range(0, 1));
            press(vb); model_load_b(vb);
            checks++; if (b !== m_b || a !== m_a || estado !== m_estado) begin errors++; $display("FAIL rnd_b[%0d] got a=%0h b=%0h st=%0d want a=%0h b=%0h st=%0d", i, a, b, estado, m_a, m_b, m_estado); end
            repeat (CALC_N) @(posedge clk);
            #1;
            model_capture();
            checks++; if (resultado !== m_res || negativo !== m_neg || cout_reg !== m_cout) begin errors++; $display("FAIL rnd_cap[%0d] got res=%0h neg=%b c=%b want res=%0h neg=%b c=%b", i, resultado, negativo, cout_reg, m_res, m_neg, m_cout); end
            checks++; if (pronto !== m_pronto || estado !== m_estado) begin errors++; $display("FAIL rnd_done[%0d] got p=%b st=%0d want p=%b st=%0d", i, pronto, estado, m_pronto, m_estado); end
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            checks++; if (estado !== m_estado || resultado !== m_res || pronto !== m_pronto) begin errors++; $display("FAIL rnd_hold[%0d] got st=%0d res=%0h p=%b want st=%0d res=%0h p=%b", i, estado, resultado, pronto, m_estado, m_res, m_pronto); end
        end
    endtask

    task automatic test_calc_ignore();
        press(4'd4);  model_load_a(4'd4);
        press(4'd11); model_load_b(4'd11);
        press(4'd15);
        press(4'd0);
        checks++; if (estado !== 2'd2 || a !== m_a || b !== m_b) begin errors++; $display("FAIL ign_during got st=%0d a=%0h b=%0h want st=2 a=%0h b=%0h", estado, a, b, m_a, m_b); end
        for (int i = 0; i < 20; i++) begin
            if (pronto === 1'b1) break;
            @(posedge clk); #1;
        end
        model_capture();
        checks++; if (pronto !== 1'b1) begin errors++; $display("FAIL ign_timeout got pronto=%b want 1", pronto); end
        checks++; if (resultado !== m_res || estado !== m_estado || a !== m_a || b !== m_b) begin errors++; $display("FAIL ign_cap got res=%0h st=%0d a=%0h b=%0h want res=%0h st=%0d a=%0h b=%0h", resultado, estado, a, b, m_res, m_estado, m_a, m_b); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (estado !== m_estado || pronto !== 1'b1) begin errors++; $display("FAIL ign_queued got st=%0d p=%b want st=3 p=1", estado, pronto); end
        press(4'd6); model_load_a(4'd6);
        checks++; if (a !== m_a || estado !== m_estado || pronto !== 1'b0) begin errors++; $display("FAIL ign_next got a=%0h st=%0d p=%b want a=%0h st=%0d p=0", a, estado, pronto, m_a, m_estado); end
    endtask

    task automatic test_reset_mid_calc();
        press(4'd2); model_load_b(4'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++; if (a !== 0 || b !== 0 || resultado !== 0 || {cout_reg, negativo, pronto} !== 3'b000 || estado !== 0) begin errors++; $display("FAIL rstcalc_async got a=%0h b=%0h res=%0h f=%b st=%0d want all 0", a, b, resultado, {cout_reg, negativo, pronto}, estado); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (CALC_N + 4) @(posedge clk);
        #1;
        checks++; if (pronto !== 1'b0 || estado !== 2'd0 || resultado !== 4'd0) begin errors++; $display("FAIL rstcalc_nocap got p=%b st=%0d res=%0h want p=0 st=0 res=0", pronto, estado, resultado); end
    endtask

    task automatic test_limpar();
        press(4'd8); model_load_a(4'd8);
        botao = 1'b0;
        repeat (SYNC) @(negedge clk);
        @(negedge clk);
        chaves = 4'd13;
        botao  = 1'b1;
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        limpar = 1'b1;
        @(posedge clk); #1;
        model_clear();
        checks++; if (estado !== 2'd0 || a !== 4'd0 || b !== 4'd0) begin errors++; $display("FAIL clr_evt got st=%0d a=%0h b=%0h want st=0 a=0 b=0", estado, a, b); end
        @(negedge clk);
        limpar = 1'b0;
        botao  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (estado !== 2'd0) begin errors++; $display("FAIL clr_stay got st=%0d want 0", estado); end
        cout_flip = 1'b1;
        press(4'd12); model_load_a(4'd12);
        press(4'd1);  model_load_b(4'd1);
        repeat (CALC_N) @(posedge clk);
        #1;
        model_capture();
        checks++; if (resultado !== m_res || cout_reg !== m_cout) begin errors++; $display("FAIL clr_pre got res=%0h c=%b want res=%0h c=%b", resultado, cout_reg, m_res, m_cout); end
        @(negedge clk);
        limpar = 1'b1;
        @(posedge clk); #1;
        model_clear();
        checks++; if (resultado !== 0 || {cout_reg, negativo, pronto} !== 3'b000 || estado !== 0 || a !== 0 || b !== 0) begin errors++; $display("FAIL clr_mostra got res=%0h f=%b st=%0d a=%0h b=%0h want all 0", resultado, {cout_reg, negativo, pronto}, estado, a, b); end
        @(negedge clk);
        limpar = 1'b0;
    endtask

    task automatic test_hold_glitch();
        @(negedge clk);
        chaves = 4'd7;
        botao  = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        model_load_a(4'd7);
        checks++; if (a !== m_a || estado !== m_estado) begin errors++; $display("FAIL hold_first got a=%0h st=%0d want a=%0h st=%0d", a, estado, m_a, m_estado); end
        chaves = 4'd2;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (estado !== m_estado || b !== m_b) begin errors++; $display("FAIL hold_100 got st=%0d b=%0h want st=%0d b=%0h", estado, b, m_estado, m_b); end
        botao = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        #1 botao = 1'b1;
        #3 botao = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (estado !== m_estado || b !== m_b) begin errors++; $display("FAIL glitch got st=%0d b=%0h want st=%0d b=%0h", estado, b, m_estado, m_b); end
        press(4'd2); model_load_b(4'd2);
        repeat (CALC_N) @(posedge clk);
        #1;
        model_capture();
        checks++; if (resultado !== 4'd5 || estado !== 2'd3) begin errors++; $display("FAIL hold_after got res=%0h st=%0d want res=5 st=3", resultado, estado); end
    endtask

    task automatic test_reset_held_press();
        @(negedge clk);
        chaves = 4'd9;
        botao  = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (10) @(posedge clk);
        #1;
        checks++; if (estado !== 2'd0 || a !== 4'd0) begin errors++; $display("FAIL held_rst got st=%0d a=%0h want st=0 a=0", estado, a); end
        @(negedge clk);
        botao = 1'b0;
        press(4'd10); model_load_a(4'd10);
        checks++; if (estado !== m_estado || a !== m_a) begin errors++; $display("FAIL held_repress got st=%0d a=%0h want st=%0d a=%0h", estado, a, m_estado, m_a); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random(25);
        test_calc_ignore();
        test_reset_mid_calc();
        test_limpar();
        test_hold_glitch();
        test_reset_held_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
